// File: rtl/cnn_pkg.sv
// Shared types for the CNN layer datapath: scheduler state encoding and the
// latched configuration bundle passed between the register block and controllers.
package cnn_pkg;

  localparam int CNN_ADDR_W = 16;
  localparam int CNN_DIM_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [CNN_DIM_W-1:0]  rows;
    logic [CNN_DIM_W-1:0]  cols;
    logic [CNN_DIM_W-1:0]  chans;
    logic [CNN_ADDR_W-1:0] in_base;
    logic [CNN_ADDR_W-1:0] w_base;
    logic [CNN_ADDR_W-1:0] out_base;
    logic [CNN_ADDR_W-1:0] col_step;
    logic [CNN_ADDR_W-1:0] row_step;
    logic [CNN_ADDR_W-1:0] w_step;
  } cnn_cfg_t;

endpackage

// File: rtl/cnn_job_scheduler_if.sv
// Job channel between the layer scheduler (master) and the per-job layer FSM (slave).
interface cnn_job_scheduler_if #(
  parameter int ADDR_W = 16
);
  // Handshake: job_start is a one-cycle issue pulse; the three addresses are
  // stable from that cycle until the next issue. The slave answers every issue
  // with exactly one job_done pulse; the master ignores job_done at other times.
  logic              job_start;
  logic [ADDR_W-1:0] job_in_addr;
  logic [ADDR_W-1:0] job_w_addr;
  logic [ADDR_W-1:0] job_out_addr;
  logic              job_done;

  modport master (
    output job_start, job_in_addr, job_w_addr, job_out_addr,
    input  job_done
  );

  modport slave (
    input  job_start, job_in_addr, job_w_addr, job_out_addr,
    output job_done
  );
endinterface

// File: rtl/cnn_loop_counter.sv
// Three-level col/row/chan loop counter, column innermost, with last-element
// flag and strobes telling the caller which loop level wraps on this step.
module cnn_loop_counter #(
  parameter int DIM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic [DIM_W-1:0] rows,
  input  logic [DIM_W-1:0] cols,
  input  logic [DIM_W-1:0] chans,
  output logic [DIM_W-1:0] col,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] chan,
  output logic             last,
  output logic             row_adv,
  output logic             chan_adv
);

  logic col_end;
  logic row_end;
  logic chan_end;

  assign col_end  = (col  == cols  - DIM_W'(1));
  assign row_end  = (row  == rows  - DIM_W'(1));
  assign chan_end = (chan == chans - DIM_W'(1));
  assign last     = col_end && row_end && chan_end;

  // Strobes qualify the step so the caller can update address accumulators in lockstep.
  assign row_adv  = step && col_end && !row_end;
  assign chan_adv = step && col_end && row_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      chan <= '0;
    end else if (clear) begin
      col  <= '0;
      row  <= '0;
      chan <= '0;
    end else if (step) begin
      if (!col_end) begin
        col <= col + DIM_W'(1);
      end else if (!row_end) begin
        col <= '0;
        row <= row + DIM_W'(1);
      end else begin
        col  <= '0;
        row  <= '0;
        chan <= chan + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/cnn_job_scheduler.sv
// Walks an output feature map one element at a time, issuing one job per
// element to the layer FSM and tracking the input/weight/output addresses.
module cnn_job_scheduler
  import cnn_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIM_W-1:0]     cfg_rows,
  input  logic [DIM_W-1:0]     cfg_cols,
  input  logic [DIM_W-1:0]     cfg_chans,
  input  logic [ADDR_W-1:0]    cfg_in_base,
  input  logic [ADDR_W-1:0]    cfg_w_base,
  input  logic [ADDR_W-1:0]    cfg_out_base,
  input  logic [ADDR_W-1:0]    cfg_col_step,
  input  logic [ADDR_W-1:0]    cfg_row_step,
  input  logic [ADDR_W-1:0]    cfg_w_step,
  cnn_job_scheduler_if.master  job,
  output logic                 busy,
  output logic                 done,
  output logic [3*DIM_W-1:0]   job_count,
  output sched_state_t         state_dbg
);

  sched_state_t      state;
  logic [DIM_W-1:0]  lat_rows, lat_cols, lat_chans;
  logic [ADDR_W-1:0] lat_in_base, lat_col_step, lat_row_step, lat_w_step;
  logic [ADDR_W-1:0] in_addr, in_row_addr, w_addr, out_addr;

  logic              dims_ok;
  logic              cnt_clear;
  logic              cnt_step;
  logic              last;
  logic              row_adv;
  logic              chan_adv;
  logic [DIM_W-1:0]  col, row, chan;
  logic [ADDR_W-1:0] next_row_addr;

  assign dims_ok       = (cfg_rows != '0) && (cfg_cols != '0) && (cfg_chans != '0);
  assign cnt_clear     = (state == IDLE) && start && dims_ok;
  // Abort wins over job_done, and the final job never steps the counters.
  assign cnt_step      = (state == WAIT) && job.job_done && !abort && !last;
  assign next_row_addr = in_row_addr + lat_row_step;

  cnn_loop_counter #(.DIM_W(DIM_W)) u_loop (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .step     (cnt_step),
    .rows     (lat_rows),
    .cols     (lat_cols),
    .chans    (lat_chans),
    .col      (col),
    .row      (row),
    .chan     (chan),
    .last     (last),
    .row_adv  (row_adv),
    .chan_adv (chan_adv)
  );

  assign job.job_start    = (state == ISSUE);
  assign job.job_in_addr  = in_addr;
  assign job.job_w_addr   = w_addr;
  assign job.job_out_addr = out_addr;
  assign busy             = (state != IDLE);
  assign done             = (state == FINISH);
  assign state_dbg        = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lat_rows     <= '0;
      lat_cols     <= '0;
      lat_chans    <= '0;
      lat_in_base  <= '0;
      lat_col_step <= '0;
      lat_row_step <= '0;
      lat_w_step   <= '0;
      in_addr      <= '0;
      in_row_addr  <= '0;
      w_addr       <= '0;
      out_addr     <= '0;
      job_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            job_count <= '0;
            if (dims_ok) begin
              lat_rows     <= cfg_rows;
              lat_cols     <= cfg_cols;
              lat_chans    <= cfg_chans;
              lat_in_base  <= cfg_in_base;
              lat_col_step <= cfg_col_step;
              lat_row_step <= cfg_row_step;
              lat_w_step   <= cfg_w_step;
              in_addr      <= cfg_in_base;
              in_row_addr  <= cfg_in_base;
              w_addr       <= cfg_w_base;
              out_addr     <= cfg_out_base;
              state        <= ISSUE;
            end else begin
              state <= FINISH;
            end
          end
        end
        ISSUE: state <= abort ? IDLE : WAIT;
        WAIT: begin
          if (abort) begin
            state <= IDLE;
          end else if (job.job_done) begin
            job_count <= job_count + (3*DIM_W)'(1);
            out_addr  <= out_addr + ADDR_W'(1);
            if (last) begin
              state <= FINISH;
            end else begin
              state <= ISSUE;
              if (chan_adv) begin
                in_addr     <= lat_in_base;
                in_row_addr <= lat_in_base;
                w_addr      <= w_addr + lat_w_step;
              end else if (row_adv) begin
                in_row_addr <= next_row_addr;
                in_addr     <= next_row_addr;
              end else begin
                in_addr <= in_addr + lat_col_step;
              end
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_cnt;
  assign unused_cnt = ^{col, row, chan};

endmodule

// File: doc/cnn_job_scheduler.md
# cnn_job_scheduler

Sequences the CNN layer controller across a full output feature map. For every output element it issues one job (start pulse plus operand addresses) and waits for that job's completion. It then advances three nested loop counters (column, row, output channel) and finally signals layer completion. It sits between the host-facing configuration registers and the per-job CNN layer FSM.

## Interface
Parameters:
- ADDR_W, 16, width of all address ports and address arithmetic
- DIM_W, 8, width of the dimension and counter config fields

Ports:
- clk  in  1  system clock; one clock domain; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  layer start; sampled only in IDLE
- abort  in  1  cancel the layer; sampled in every non-IDLE state
- cfg_rows, cfg_cols, cfg_chans  in  DIM_W each  output height, width and channel count
- cfg_in_base, cfg_w_base, cfg_out_base  in  ADDR_W each  base addresses
- cfg_col_step  in  ADDR_W  input address step per column (equals the stride)
- cfg_row_step  in  ADDR_W  input address step per row (stride × input pitch; precomputed by software)
- cfg_w_step  in  ADDR_W  weight address step per output channel
- job_done  in  1  completion pulse from the layer FSM
- job_start  out  1  one-cycle job issue pulse
- job_in_addr, job_w_addr, job_out_addr  out  ADDR_W each  operand addresses; valid while busy
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle layer-complete pulse
- job_count  out  3*DIM_W  number of jobs completed in the current or last layer

## Operation
- States: IDLE, ISSUE, WAIT, FINISH.
- **IDLE**
  - On start with every cfg dimension nonzero:
    - latch all cfg fields;
    - zero the col, row and chan counters and job_count;
    - set in_addr = in_row_addr = cfg_in_base, w_addr = cfg_w_base, out_addr = cfg_out_base;
    - go to ISSUE.
  - On start with any dimension zero: go to FINISH. No jobs are issued and job_count is 0.
  - Otherwise remain in IDLE.
- **ISSUE**: job_start = 1; go to WAIT.
- **WAIT**: job_done is sampled only in this state and is ignored in all others. On job_done:
  - job_count += 1 and out_addr += 1;
  - if this was the last job (col = cols−1, row = rows−1, chan = chans−1), go to FINISH;
  - otherwise step the loops and go to ISSUE.
- **Loop step**, column innermost:
  - If col < cols−1: col += 1 and in_addr += col_step.
  - Else, if row < rows−1: col = 0, row += 1, in_row_addr += row_step, in_addr = new in_row_addr.
  - Else: col = row = 0, chan += 1, in_addr = in_row_addr = in_base, w_addr += w_step.
- **FINISH**: done = 1; go to IDLE.
- **abort**
  - In ISSUE, WAIT or FINISH, abort forces IDLE on the next edge.
  - It takes priority over job_done.
  - No done pulse follows an abort, and job_count holds its value.
  - An abort arriving in ISSUE still leaves that cycle's job_start asserted.
- start while busy is ignored. Cfg inputs may change freely while busy; only the latched copies are used.
- All address arithmetic wraps modulo 2^ADDR_W. Counters compare against the latched dimensions.

## Timing
- After reset: state IDLE; job_start, done and busy at 0; all addresses and job_count at 0.
- Reset mid-layer returns to IDLE immediately, with no done pulse.
- job_start, done and busy are decoded from the registered state. Address outputs are registered.
- Start sampled at edge 0 → job_start high in cycle 1 with addresses already valid.
- job_done in WAIT cycle n → next job_start in cycle n+1 (minimum two cycles per job). For the last job, done is high in cycle n+1 and state is IDLE in cycle n+2.
- Zero-dimension start at edge 0 → done in cycle 1 and busy high for that cycle only.

## Structure
- Shared package cnn_pkg holds:
  - the sched_state_t enum (IDLE=0, ISSUE=1, WAIT=2, FINISH=3);
  - a typedef for the latched cfg bundle, used by the layer FSM and by the register block.
- One natural sub-module, cnn_loop_counter: the three-level col/row/chan counter with a last flag and a row-wrap/chan-wrap strobe. The top level holds the FSM and the address accumulators.

## Test plan
- rows=2, cols=3, chans=1, in_base=0x100, col_step=1, row_step=5, out_base=0x200; job_done two cycles after each job_start
  → 6 jobs; in_addr 0x100, 0x101, 0x102, 0x105, 0x106, 0x107; out_addr 0x200–0x205; one done pulse; job_count=6.
- rows=1, cols=2, chans=2, w_base=0x40, w_step=9
  → w_addr 0x40, 0x40, 0x49, 0x49; in_addr returns to in_base at the channel wrap.
- cols=0 → done in cycle 1, no job_start, job_count=0.
- abort asserted together with job_done in WAIT of the 3rd job
  → IDLE next cycle, no done, job_count=2.
- start pulsed mid-layer, and job_done pulsed in ISSUE/IDLE
  → both ignored; job sequence unchanged.
- rst asserted while in WAIT
  → all outputs 0 asynchronously; a fresh start runs a complete layer correctly.
